pifctl_regbank: RTL and testbench

- Parametrised successor to the PIF control register block on the XI register bus (xclk domain).
- Holds NUM_SCRATCH writable scratch registers, a MISC_BITS misc/LED register and a sticky clear-on-read event status register.
- Write-lock key protects the scratch and misc registers.
- Presents the whole bank through the R_ID sub-addressed readback path with a configurable, fixed pipeline latency.

---
 rtl/pifctl_regbank_pkg.sv | 51 +++++
 rtl/pifctl_regbank_rd_pipe.sv | 37 +++
 rtl/pifctl_regbank.sv | 157 +++++++++++++++
 tb/tb_pifctl_regbank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pifctl_regbank_pkg.sv
// pifctl_regbank_pkg: shared constants for the PIF control register bank.
//   - Default XI bus geometry and register addresses.
//   - Readback prefix nibbles for each field class.
//   - Sub-address class enum plus helpers that place misc/status after the
//     scratch block, however many scratch registers a build has.
package pifctl_regbank_pkg;

  localparam int XA_BITS       = 3;
  localparam int ADDR_BITS_DEF = 2 ** XA_BITS;
  localparam int XSUBA_MAX     = 3;
  localparam int SUBA_BITS_DEF = XSUBA_MAX + 1;

  localparam logic [7:0] ID_DEF        = 8'hA5;
  localparam logic [3:0] LED_SYNC      = 4'h5;
  localparam logic [7:0] W_SCRATCH_REG = 8'h10;
  localparam logic [7:0] W_MISC_REG    = 8'h18;
  localparam logic [7:0] W_LOCK_REG    = 8'h19;
  localparam logic [7:0] R_ID          = 8'h01;
  localparam logic [5:0] LOCK_KEY_DEF  = 6'h2A;

  // Upper nibble of the readback byte identifies which field is returned.
  localparam logic [3:0] PFX_SCRATCH = 4'h4;
  localparam logic [3:0] PFX_MISC    = 4'h5;
  localparam logic [3:0] PFX_LETTER  = 4'h6;
  localparam logic [3:0] PFX_STAT    = 4'h7;

  typedef enum logic [2:0] {
    SUB_ID,
    SUB_SCRATCH,
    SUB_MISC,
    SUB_STAT,
    SUB_LETTER
  } sub_class_e;

  function automatic int s_misc(input int num_scratch);
    return num_scratch + 1;
  endfunction

  function automatic int s_stat(input int num_scratch);
    return num_scratch + 2;
  endfunction

  function automatic sub_class_e sub_class(input int sub, input int num_scratch);
    if (sub == 0)                        return SUB_ID;
    else if (sub <= num_scratch)         return SUB_SCRATCH;
    else if (sub == s_misc(num_scratch)) return SUB_MISC;
    else if (sub == s_stat(num_scratch)) return SUB_STAT;
    else                                 return SUB_LETTER;
  endfunction

endpackage

// File: rtl/pifctl_regbank_rd_pipe.sv
// pifctl_regbank_rd_pipe: fixed-depth delay line used as the readback tail.
//   xclk - clock
//   rst  - synchronous active-high reset, flushes every stage to 0
//   din  - WIDTH-bit input
//   dout - din delayed by DEPTH cycles (combinational pass-through if DEPTH=0)
module pifctl_regbank_rd_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             xclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_delay
      logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

      always_ff @(posedge xclk) begin
        if (rst) begin
          stage_reg <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pifctl_regbank.sv
// pifctl_regbank: PIF control register bank on the XI register bus.
//   xclk           - clock
//   rst            - synchronous active-high reset
//   XI_PWr         - write strobe (one cycle)
//   XI_PRWA        - read/write address
//   XI_PRdFinished - end-of-read pulse; clears status when reading S_STAT
//   XI_PRdSubA     - readback sub-address
//   XI_PD          - write data
//   EventIn        - level event inputs, OR'd into sticky status
//   XO             - readback byte, RD_LAT-1 cycles after inputs are sampled
//   MiscReg        - registered copy of the misc register
//   Locked         - 1 while scratch/misc writes are blocked
module pifctl_regbank
  import pifctl_regbank_pkg::*;
#(
  parameter int                    DATA_BITS      = 6,
  parameter int                    ADDR_BITS      = ADDR_BITS_DEF,
  parameter int                    SUBA_BITS      = SUBA_BITS_DEF,
  parameter int                    NUM_SCRATCH    = 4,
  parameter int                    MISC_BITS      = 4,
  parameter int                    STAT_BITS      = 4,
  parameter int                    RD_LAT         = 5,
  parameter logic [7:0]            ID_VALUE       = ID_DEF,
  parameter logic [DATA_BITS-1:0]  SCRATCH_RST    = 6'h15,
  parameter logic [MISC_BITS-1:0]  MISC_RST       = LED_SYNC,
  parameter logic [ADDR_BITS-1:0]  W_SCRATCH_BASE = W_SCRATCH_REG,
  parameter logic [ADDR_BITS-1:0]  W_MISC         = W_MISC_REG,
  parameter logic [ADDR_BITS-1:0]  W_LOCK         = W_LOCK_REG,
  parameter logic [ADDR_BITS-1:0]  R_ID_ADDR      = R_ID,
  parameter logic [DATA_BITS-1:0]  LOCK_KEY       = LOCK_KEY_DEF
) (
  input  logic                 xclk,
  input  logic                 rst,
  input  logic                 XI_PWr,
  input  logic [ADDR_BITS-1:0] XI_PRWA,
  input  logic                 XI_PRdFinished,
  input  logic [SUBA_BITS-1:0] XI_PRdSubA,
  input  logic [DATA_BITS-1:0] XI_PD,
  input  logic [STAT_BITS-1:0] EventIn,
  output logic [7:0]           XO,
  output logic [MISC_BITS-1:0] MiscReg,
  output logic                 Locked
);

  localparam int S_MISC = s_misc(NUM_SCRATCH);
  localparam int S_STAT = s_stat(NUM_SCRATCH);

  logic [DATA_BITS-1:0]   scratch_reg [NUM_SCRATCH];
  logic [NUM_SCRATCH-1:0] scr_we;
  logic [MISC_BITS-1:0]   misc_reg;
  logic [MISC_BITS-1:0]   misc_out_reg;
  logic [STAT_BITS-1:0]   status_reg;
  logic [STAT_BITS-1:0]   clr;
  logic                   locked_reg;

  logic [SUBA_BITS-1:0]   sub1_reg;
  logic [7:0]             src1_reg;
  logic                   hit1_reg;
  logic [7:0]             src_sel;
  logic [7:0]             byte_mux;
  logic [3:0]             sub_lo;
  logic [7:0]             stage2_reg;

  // ---------------- register writes ----------------
  generate
    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr_we
      assign scr_we[gi] = XI_PWr && !locked_reg &&
                          (XI_PRWA == ADDR_BITS'(W_SCRATCH_BASE + gi));
    end
  endgenerate

  always_ff @(posedge xclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_reg[i] <= SCRATCH_RST;
      misc_reg     <= MISC_RST;
      misc_out_reg <= MISC_RST;
      locked_reg   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scr_we[i]) scratch_reg[i] <= XI_PD;
      end
      if (XI_PWr && !locked_reg && XI_PRWA == W_MISC) misc_reg <= MISC_BITS'(XI_PD);
      // The lock register itself is always writable, otherwise the bank
      // could never be unlocked again.
      if (XI_PWr && XI_PRWA == W_LOCK) locked_reg <= (XI_PD != LOCK_KEY);
      misc_out_reg <= misc_reg;
    end
  end

  // ---------------- sticky status ----------------
  // Clear applies only at the end of a status read; a simultaneous event
  // still sets its bit because the OR comes after the mask.
  assign clr = {STAT_BITS{XI_PRdFinished && (XI_PRWA == R_ID_ADDR) &&
                          (int'(XI_PRdSubA) == S_STAT)}};

  always_ff @(posedge xclk) begin
    if (rst) status_reg <= '0;
    else     status_reg <= (status_reg & ~clr) | EventIn;
  end

  // ---------------- readback stage 1: snapshot ----------------
  always_comb begin
    src_sel = 8'h00;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (int'(XI_PRdSubA) == i + 1) src_sel = 8'(scratch_reg[i]);
    end
    if (int'(XI_PRdSubA) == S_MISC) src_sel = 8'(misc_reg);
    if (int'(XI_PRdSubA) == S_STAT) src_sel = 8'(status_reg);
  end

  always_ff @(posedge xclk) begin
    if (rst) begin
      sub1_reg <= '0;
      src1_reg <= 8'h00;
      hit1_reg <= 1'b0;
    end else begin
      sub1_reg <= XI_PRdSubA;
      src1_reg <= src_sel;
      hit1_reg <= (XI_PRWA == R_ID_ADDR);
    end
  end

  // ---------------- readback stage 2: format byte ----------------
  assign sub_lo = 4'(sub1_reg);

  always_comb begin
    byte_mux = 8'h00;
    case (sub_class(int'(sub1_reg), NUM_SCRATCH))
      SUB_ID:      byte_mux = ID_VALUE;
      SUB_SCRATCH: byte_mux = {PFX_SCRATCH, 4'h0} | src1_reg;
      SUB_MISC:    byte_mux = {PFX_MISC, 4'h0} | src1_reg;
      SUB_STAT:    byte_mux = {PFX_STAT, 4'h0} | src1_reg;
      default:     byte_mux = {PFX_LETTER, sub_lo};
    endcase
  end

  always_ff @(posedge xclk) begin
    if (rst)           stage2_reg <= 8'h00;
    else if (hit1_reg) stage2_reg <= byte_mux;
    else               stage2_reg <= 8'h00;
  end

  // Remaining RD_LAT-2 stages pad the path out to the fixed latency.
  pifctl_regbank_rd_pipe #(
    .WIDTH (8),
    .DEPTH (RD_LAT - 2)
  ) u_tail (
    .xclk (xclk),
    .rst  (rst),
    .din  (stage2_reg),
    .dout (XO)
  );

  assign MiscReg = misc_out_reg;
  assign Locked  = locked_reg;

endmodule

// File: tb/tb_pifctl_regbank.sv
// tb_pifctl_regbank: drives RD_LAT=5, 2 and 8 builds with identical stimulus.
// Expected responses are queued with their due cycle; a monitor pops and
// compares them against the DUT outputs on the falling edge.
module tb_pifctl_regbank;

  localparam logic [7:0] A_IDLE  = 8'h00;
  localparam logic [7:0] A_RID   = 8'h01;
  localparam logic [7:0] A_OTHER = 8'h02;
  localparam logic [7:0] A_SCR0  = 8'h10;
  localparam logic [7:0] A_SCR2  = 8'h12;
  localparam logic [7:0] A_MISC  = 8'h18;
  localparam logic [7:0] A_LOCK  = 8'h19;

  localparam int K_XO   = 0;
  localparam int K_LOCK = 1;
  localparam int K_MISC = 2;

  logic       xclk = 1'b0;
  logic       rst = 1'b1;
  logic       XI_PWr = 1'b0;
  logic [7:0] XI_PRWA = 8'h00;
  logic       XI_PRdFinished = 1'b0;
  logic [3:0] XI_PRdSubA = 4'h0;
  logic [5:0] XI_PD = 6'h00;
  logic [3:0] EventIn = 4'h0;

  logic [7:0] xo5, xo2, xo8;
  logic [3:0] misc5, misc2, misc8;
  logic       lk5, lk2, lk8;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 xclk = ~xclk;
  always @(posedge xclk) cyc <= cyc + 1;

  pifctl_regbank #(.RD_LAT(5)) u_dut5 (
    .xclk(xclk), .rst(rst), .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA),
    .XI_PRdFinished(XI_PRdFinished), .XI_PRdSubA(XI_PRdSubA), .XI_PD(XI_PD),
    .EventIn(EventIn), .XO(xo5), .MiscReg(misc5), .Locked(lk5));

  pifctl_regbank #(.RD_LAT(2)) u_dut2 (
    .xclk(xclk), .rst(rst), .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA),
    .XI_PRdFinished(XI_PRdFinished), .XI_PRdSubA(XI_PRdSubA), .XI_PD(XI_PD),
    .EventIn(EventIn), .XO(xo2), .MiscReg(misc2), .Locked(lk2));

  pifctl_regbank #(.RD_LAT(8)) u_dut8 (
    .xclk(xclk), .rst(rst), .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA),
    .XI_PRdFinished(XI_PRdFinished), .XI_PRdSubA(XI_PRdSubA), .XI_PD(XI_PD),
    .EventIn(EventIn), .XO(xo8), .MiscReg(misc8), .Locked(lk8));

  typedef struct {
    int         due;
    int         kind;
    int         lat;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sbq[$];

  // Keep the queue ordered by due cycle so the monitor only looks at the head.
  function automatic void push(input int due, input int kind, input int lat,
                               input logic [7:0] exp, input string name);
    exp_t e;
    int   pos;
    e.due  = due;
    e.kind = kind;
    e.lat  = lat;
    e.exp  = exp;
    e.name = name;
    pos = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].due > due) begin
        pos = i;
        break;
      end
    end
    sbq.insert(pos, e);
  endfunction

  function automatic logic [7:0] actual(input int kind, input int lat);
    if (kind == K_LOCK) return {7'b0, lk5};
    if (kind == K_MISC) return {4'b0, misc5};
    case (lat)
      2:       return xo2;
      8:       return xo8;
      default: return xo5;
    endcase
  endfunction

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge xclk) begin : monitor
    exp_t       e;
    logic [7:0] act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e   = sbq.pop_front();
      act = actual(e.kind, e.lat);
      n_checks++;
      if (e.due != cyc || act !== e.exp) begin
        n_errors++;
        $display("FAIL %s cyc=%0d due=%0d got=%02h want=%02h", e.name, cyc, e.due, act, e.exp);
      end else begin
        $display("ok   %s cyc=%0d got=%02h", e.name, cyc, act);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge xclk);
  endtask

  // Read: hold address/sub for 10 cycles. XO must still show the idle 0 one
  // cycle before the expected latency and the new byte exactly at it.
  task automatic do_read(input logic [7:0] addr, input logic [3:0] sub,
                         input logic [7:0] exp, input string name);
    int lats[3] = '{2, 5, 8};
    @(negedge xclk);
    XI_PRWA    = addr;
    XI_PRdSubA = sub;
    foreach (lats[i]) begin
      push(cyc + lats[i] - 1, K_XO, lats[i], 8'h00, $sformatf("%s_pre/L%0d", name, lats[i]));
      push(cyc + lats[i],     K_XO, lats[i], exp,   $sformatf("%s/L%0d", name, lats[i]));
    end
    tick(10);
    XI_PRWA    = A_IDLE;
    XI_PRdSubA = 4'h0;
    tick(10);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [5:0] d);
    @(negedge xclk);
    XI_PWr  = 1'b1;
    XI_PRWA = addr;
    XI_PD   = d;
    @(negedge xclk);
    XI_PWr  = 1'b0;
    XI_PRWA = A_IDLE;
    XI_PD   = 6'h00;
  endtask

  task automatic pulse_event(input logic [3:0] ev);
    @(negedge xclk);
    EventIn = ev;
    @(negedge xclk);
    EventIn = 4'h0;
    tick(2);
  endtask

  // End-of-read pulse on the status sub-address, optionally with a new event.
  task automatic finish_stat(input logic [3:0] ev);
    @(negedge xclk);
    XI_PRWA        = A_RID;
    XI_PRdSubA     = 4'd6;
    XI_PRdFinished = 1'b1;
    EventIn        = ev;
    @(negedge xclk);
    XI_PRWA        = A_IDLE;
    XI_PRdSubA     = 4'h0;
    XI_PRdFinished = 1'b0;
    EventIn        = 4'h0;
    tick(12);
  endtask

  initial begin
    int lats[3] = '{2, 5, 8};
    int j;

    tick(3);
    rst = 1'b0;
    foreach (lats[i]) push(cyc + 1, K_XO, lats[i], 8'h00, $sformatf("rst_xo/L%0d", lats[i]));
    push(cyc + 1, K_LOCK, 5, 8'h00, "rst_locked");
    push(cyc + 1, K_MISC, 5, 8'h05, "rst_misc");
    tick(3);

    // Default readback
    do_read(A_RID, 4'd0, 8'hA5, "id");
    do_read(A_RID, 4'd1, 8'h55, "scr0_def");
    do_read(A_RID, 4'd5, 8'h55, "misc_def");
    do_read(A_RID, 4'd6, 8'h70, "stat_def");

    // Scratch write and address gating
    do_write(A_SCR2, 6'h3F);
    tick(12);
    do_read(A_RID, 4'd3, 8'h7F, "scr2_3f");
    do_read(A_OTHER, 4'd3, 8'h00, "not_rid");

    // Locked: writes dropped
    do_write(A_LOCK, 6'h01);
    push(cyc + 1, K_LOCK, 5, 8'h01, "lock_set");
    tick(4);
    do_write(A_SCR0, 6'h0A);
    tick(12);
    do_read(A_RID, 4'd1, 8'h55, "scr0_locked");
    do_write(A_MISC, 6'h0F);
    push(cyc + 2, K_MISC, 5, 8'h05, "misc_locked");
    tick(12);

    // Unlock with key: writes land
    do_write(A_LOCK, 6'h2A);
    push(cyc + 1, K_LOCK, 5, 8'h00, "lock_clr");
    tick(4);
    do_write(A_SCR0, 6'h0A);
    tick(12);
    do_read(A_RID, 4'd1, 8'h4A, "scr0_unlocked");
    do_write(A_MISC, 6'h03);
    push(cyc + 2, K_MISC, 5, 8'h03, "misc_unlocked");
    tick(12);
    do_read(A_RID, 4'd5, 8'h53, "misc_rd");

    // Sticky status with clear-on-read
    pulse_event(4'b0101);
    do_read(A_RID, 4'd6, 8'h75, "stat_set");
    finish_stat(4'b1000);
    do_read(A_RID, 4'd6, 8'h78, "stat_clr_setwins");
    finish_stat(4'b0000);
    do_read(A_RID, 4'd6, 8'h70, "stat_cleared");

    // Letter series
    do_read(A_RID, 4'd7,  8'h67, "letter7");
    do_read(A_RID, 4'd15, 8'h6F, "letter15");

    // Reset while a scratch0 read (value 4A) is in flight, with lock set
    do_write(A_LOCK, 6'h01);
    push(cyc + 1, K_LOCK, 5, 8'h01, "lock_set2");
    tick(12);
    @(negedge xclk);
    XI_PRWA    = A_RID;
    XI_PRdSubA = 4'd1;
    tick(2);
    rst = 1'b1;
    j = cyc;
    foreach (lats[i]) begin
      push(j + 1,           K_XO, lats[i], 8'h00, $sformatf("midrst_flush/L%0d", lats[i]));
      push(j + lats[i],     K_XO, lats[i], 8'h00, $sformatf("midrst_last0/L%0d", lats[i]));
      push(j + lats[i] + 1, K_XO, lats[i], 8'h55, $sformatf("midrst_scr0/L%0d", lats[i]));
    end
    push(j + 2, K_LOCK, 5, 8'h00, "midrst_locked");
    push(j + 2, K_MISC, 5, 8'h05, "midrst_misc");
    @(negedge xclk);
    rst = 1'b0;
    tick(12);
    XI_PRWA    = A_IDLE;
    XI_PRdSubA = 4'h0;

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge xclk);
    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d want=0", sbq.size());
      n_errors += sbq.size();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
